// File: rtl/apa102_rx_multi_if.sv
// APA102 receiver bus: raw pad-side sck/sda plus the decoded frame outputs.
// APA102_BRIGHT_EN adds bright_out; NUM_LEDS/CBITS must match the receiver's.
interface apa102_rx_multi_if #(
    parameter int NUM_LEDS = 7,
    parameter int CBITS    = 3
);
    logic                        sck;
    logic                        sda;
    logic [NUM_LEDS*3*CBITS-1:0] data_out;
    logic                        frame_valid;
    logic                        frame_err;
    logic                        busy;
`ifdef APA102_BRIGHT_EN
    logic [NUM_LEDS*5-1:0]       bright_out;

    modport master (
        output sck, sda,
        input  data_out, frame_valid, frame_err, busy, bright_out
    );
    modport slave (
        input  sck, sda,
        output data_out, frame_valid, frame_err, busy, bright_out
    );
`else
    modport master (
        output sck, sda,
        input  data_out, frame_valid, frame_err, busy
    );
    modport slave (
        input  sck, sda,
        output data_out, frame_valid, frame_err, busy
    );
`endif
endinterface

// File: rtl/apa102_rx_multi.sv
// APA102 SPI frame receiver: keeps top CBITS of each colour byte for NUM_LEDS LEDs (APA102_BRIGHT_EN adds bright_out).
// Latency: data_out/frame_valid SYNC_STAGES+2 clk cycles after the raw sck rise carrying the last colour bit.
// Backpressure: none; the serial stream is free-running and data_out is simply overwritten per good frame.
module apa102_rx_multi #(
    parameter int NUM_LEDS    = 7,
    parameter int CBITS       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int END_BITS    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    apa102_rx_multi_if.slave bus
);
    localparam int DW = NUM_LEDS * 3 * CBITS;
    localparam int IW = (DW > 1) ? $clog2(DW) : 1;
    localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int EW = $clog2(END_BITS + 1);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_ARMED = 3'd1,
        ST_HDR   = 3'd2,
        ST_COL   = 3'd3,
        ST_END   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   sck_prev;
    logic                   bit_edge;
    logic                   bit_dat;

    state_t        state_q, state_d;
    logic [4:0]    zcnt_q, zcnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [LW-1:0] led_q, led_d;
    logic [EW-1:0] end_q, end_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] data_q;
    logic          fv_q, fv_d;
    logic          fe_q, fe_d;
    logic          commit;
    int            col_idx;

    // Equal-depth chains keep sda aligned with sck; the edge and its data bit are
    // registered once more so the FSM sees a clean single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            sda_sync <= '0;
            sck_prev <= 1'b0;
            bit_edge <= 1'b0;
            bit_dat  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
            sck_prev <= sck_sync[SYNC_STAGES-1];
            bit_edge <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
            bit_dat  <= sda_sync[SYNC_STAGES-1];
        end
    end

`ifdef APA102_BRIGHT_EN
    localparam int BRW = NUM_LEDS * 5;
    localparam int BIW = $clog2(BRW);
    logic [BRW-1:0] bright_sh_q, bright_sh_d;
    logic [BRW-1:0] bright_q;
    int             br_idx;
`endif

    always_comb begin
        state_d  = state_q;
        zcnt_d   = zcnt_q;
        bit_d    = bit_q;
        led_d    = led_q;
        end_d    = end_q;
        shadow_d = shadow_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        commit   = 1'b0;
        col_idx  = DW - 1 - (int'(led_q) * 3 + int'(bit_q[4:3])) * CBITS - int'(bit_q[2:0]);
`ifdef APA102_BRIGHT_EN
        bright_sh_d = bright_sh_q;
        br_idx      = BRW - 1 - int'(led_q) * 5 - (int'(bit_q) - 3);
`endif
        case (state_q)
            ST_START: begin
                if (bit_edge) begin
                    if (bit_dat) begin
                        zcnt_d = '0;
                    end else if (zcnt_q == 5'd31) begin
                        zcnt_d  = '0;
                        state_d = ST_ARMED;
                    end else begin
                        zcnt_d = zcnt_q + 5'd1;
                    end
                end
            end
            ST_ARMED: begin
                if (bit_edge && bit_dat) begin
                    state_d = ST_HDR;
                    bit_d   = 5'd1;
                    led_d   = '0;
                end
            end
            ST_HDR: begin
                if (bit_edge) begin
                    // Header bits 0..2 are the 3'b111 marker; bit 0 of LED0 was consumed in ARMED.
                    if (bit_q < 5'd3 && !bit_dat) begin
                        fe_d     = 1'b1;
                        state_d  = ST_START;
                        zcnt_d   = '0;
                        bit_d    = '0;
                        led_d    = '0;
                        shadow_d = '0;
`ifdef APA102_BRIGHT_EN
                        bright_sh_d = '0;
`endif
                    end else begin
`ifdef APA102_BRIGHT_EN
                        if (bit_q >= 5'd3) begin
                            bright_sh_d[br_idx[BIW-1:0]] = bit_dat;
                        end
`endif
                        if (bit_q == 5'd7) begin
                            bit_d   = '0;
                            state_d = ST_COL;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            ST_COL: begin
                if (bit_edge) begin
                    if (int'(bit_q[2:0]) < CBITS) begin
                        shadow_d[col_idx[IW-1:0]] = bit_dat;
                    end
                    if (bit_q == 5'd23) begin
                        bit_d = '0;
                        if (led_q == LW'(NUM_LEDS - 1)) begin
                            commit  = 1'b1;
                            fv_d    = 1'b1;
                            end_d   = '0;
                            state_d = ST_END;
                        end else begin
                            led_d   = led_q + LW'(1);
                            state_d = ST_HDR;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            ST_END: begin
                if (bit_edge) begin
                    if (end_q == EW'(END_BITS - 1)) begin
                        end_d   = '0;
                        zcnt_d  = '0;
                        led_d   = '0;
                        state_d = ST_START;
                    end else begin
                        end_d = end_q + EW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_START;
                zcnt_d  = '0;
                bit_d   = '0;
                led_d   = '0;
                end_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_START;
            zcnt_q   <= '0;
            bit_q    <= '0;
            led_q    <= '0;
            end_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            zcnt_q   <= zcnt_d;
            bit_q    <= bit_d;
            led_q    <= led_d;
            end_q    <= end_d;
            shadow_q <= shadow_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
            // Copy from shadow_d so a stored final colour bit lands in this frame.
            if (commit) begin
                data_q <= shadow_d;
            end
        end
    end

`ifdef APA102_BRIGHT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_sh_q <= '0;
            bright_q    <= '0;
        end else begin
            bright_sh_q <= bright_sh_d;
            if (commit) begin
                bright_q <= bright_sh_d;
            end
        end
    end

    assign bus.bright_out = bright_q;
`endif

    assign bus.data_out    = data_q;
    assign bus.frame_valid = fv_q;
    assign bus.frame_err   = fe_q;
    assign bus.busy        = (state_q == ST_HDR) || (state_q == ST_COL) || (state_q == ST_END);

endmodule

// File: tb/tb_apa102_rx_multi.sv
// Directed bench for apa102_rx_multi: default 7x3 instance plus a 2-LED, 8-bit instance.
// Honours APA102_BRIGHT_EN when defined.
module tb_apa102_rx_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    apa102_rx_multi_if #(.NUM_LEDS(7), .CBITS(3)) bus_a ();
    apa102_rx_multi_if #(.NUM_LEDS(2), .CBITS(8)) bus_b ();

    apa102_rx_multi #(.NUM_LEDS(7), .CBITS(3), .SYNC_STAGES(2), .END_BITS(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    apa102_rx_multi #(.NUM_LEDS(2), .CBITS(8), .SYNC_STAGES(2), .END_BITS(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int tests = 0;
    int fails = 0;
    int fv_a = 0, fe_a = 0, both_a = 0, fv_b = 0;

    always @(posedge clk) begin
        if (bus_a.frame_valid) fv_a++;
        if (bus_a.frame_err) fe_a++;
        if (bus_a.frame_valid && bus_a.frame_err) both_a++;
        if (bus_b.frame_valid) fv_b++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input bit sel, input logic b);
        if (sel) begin
            bus_b.sda = b; #40 bus_b.sck = 1'b1; #40 bus_b.sck = 1'b0;
        end else begin
            bus_a.sda = b; #40 bus_a.sck = 1'b1; #40 bus_a.sck = 1'b0;
        end
    endtask

    task automatic send_n(input bit sel, input logic b, input int n);
        for (int i = 0; i < n; i++) send_bit(sel, b);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(sel, v[i]);
    endtask

    task automatic send_led_default();
        send_byte(0, 8'hFF); send_byte(0, 8'hA0); send_byte(0, 8'h55); send_byte(0, 8'h0F);
    endtask

    // LED k: header E0|k, colours {k,7-k,7} in the top three bits.
    task automatic send_led_pat(input int k);
        logic [2:0] kk;
        logic [2:0] nk;
        kk = 3'(k);
        nk = 3'(7 - k);
        send_byte(0, {5'b11100, kk});
        send_byte(0, {kk, 5'b0});
        send_byte(0, {nk, 5'b0});
        send_byte(0, 8'hFF);
    endtask

    task automatic send_default_frame();
        send_n(0, 1'b0, 32);
        for (int k = 0; k < 7; k++) send_led_default();
        send_n(0, 1'b1, 32);
        #100;
    endtask

    task automatic send_pat_frame();
        send_n(0, 1'b0, 32);
        for (int k = 0; k < 7; k++) send_led_pat(k);
        send_n(0, 1'b1, 32);
        #100;
    endtask

    logic [62:0] exp_def;
    logic [62:0] exp_pat;
    logic [34:0] exp_br_def;
    logic [34:0] exp_br_pat;
    int          base_fv;
    int          base_fe;

    initial begin
        bus_a.sck = 1'b0; bus_a.sda = 1'b0;
        bus_b.sck = 1'b0; bus_b.sda = 1'b0;
        exp_def    = {7{9'b101_010_000}};
        exp_br_def = {7{5'h1F}};
        for (int k = 0; k < 7; k++) begin
            exp_pat[62 - 9*k -: 9]    = {3'(k), 3'(7 - k), 3'b111};
            exp_br_pat[34 - 5*k -: 5] = {2'b00, 3'(k)};
        end

        // Reset state, then a second reset pulse in the middle of idle.
        repeat (3) @(negedge clk);
        chk("rst_data_a", 64'(bus_a.data_out), 64'd0);
        chk("rst_fv_a", 64'(bus_a.frame_valid), 64'd0);
        chk("rst_busy_a", 64'(bus_a.busy), 64'd0);
        chk("rst_data_b", 64'(bus_b.data_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("idle_rst_data", 64'(bus_a.data_out), 64'd0);
        chk("idle_rst_fe", 64'(bus_a.frame_err), 64'd0);
        chk("idle_rst_busy", 64'(bus_a.busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Default frame, with a mid-frame look at busy and data_out stability.
        send_n(0, 1'b0, 32);
        send_led_default();
        send_led_default();
        #40;
        chk("mid_busy", 64'(bus_a.busy), 64'd1);
        chk("mid_data_stable", 64'(bus_a.data_out), 64'd0);
        for (int k = 2; k < 7; k++) send_led_default();
        send_n(0, 1'b1, 32);
        #100;
        chk("def_fv_count", 64'(fv_a), 64'd1);
        chk("def_fe_count", 64'(fe_a), 64'd0);
        chk("def_data", 64'(bus_a.data_out), 64'(exp_def));
        chk("def_busy_after_end", 64'(bus_a.busy), 64'd0);
`ifdef APA102_BRIGHT_EN
        chk("def_bright", 64'(bus_a.bright_out), 64'(exp_br_def));
`endif

        // LED2 header 0x7F: error on its bit 0, previous frame kept.
        send_n(0, 1'b0, 32);
        send_led_pat(0);
        send_led_pat(1);
        send_bit(0, 1'b0);
        #60;
        chk("hdr_err_count", 64'(fe_a), 64'd1);
        chk("hdr_err_busy", 64'(bus_a.busy), 64'd0);
        send_n(0, 1'b1, 7);
        send_byte(0, 8'hA0); send_byte(0, 8'h55); send_byte(0, 8'h0F);
        send_n(0, 1'b1, 32);
        #100;
        chk("hdr_err_no_fv", 64'(fv_a), 64'd1);
        chk("hdr_err_data_held", 64'(bus_a.data_out), 64'(exp_def));
        send_pat_frame();
        chk("after_err_fv", 64'(fv_a), 64'd2);
        chk("after_err_data", 64'(bus_a.data_out), 64'(exp_pat));
`ifdef APA102_BRIGHT_EN
        chk("after_err_bright", 64'(bus_a.bright_out), 64'(exp_br_pat));
`endif

        // 31 zeros then a 1 must not arm; the following proper frame decodes.
        send_n(0, 1'b0, 31);
        send_bit(0, 1'b1);
        send_default_frame();
        chk("short_start_fv", 64'(fv_a), 64'd3);
        chk("short_start_fe", 64'(fe_a), 64'd1);
        chk("short_start_data", 64'(bus_a.data_out), 64'(exp_def));

        // Reset while LED4 colour bits are arriving.
        send_n(0, 1'b0, 32);
        for (int k = 0; k < 4; k++) send_led_pat(k);
        send_byte(0, 8'hE4);
        send_n(0, 1'b1, 10);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", 64'(bus_a.data_out), 64'd0);
        chk("midrst_busy", 64'(bus_a.busy), 64'd0);
        chk("midrst_fv", 64'(bus_a.frame_valid), 64'd0);
`ifdef APA102_BRIGHT_EN
        chk("midrst_bright", 64'(bus_a.bright_out), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        base_fv = fv_a;
        base_fe = fe_a;
        send_pat_frame();
        chk("postrst_fv", 64'(fv_a), 64'(base_fv + 1));
        chk("postrst_fe", 64'(fe_a), 64'(base_fe));
        chk("postrst_data", 64'(bus_a.data_out), 64'(exp_pat));
        chk("valid_err_exclusive", 64'(both_a), 64'd0);

        // Two LEDs at full colour depth, 40-zero start.
        send_n(1, 1'b0, 40);
        send_byte(1, 8'hE1); send_byte(1, 8'h12); send_byte(1, 8'h34); send_byte(1, 8'h56);
        send_byte(1, 8'hFF); send_byte(1, 8'hAB); send_byte(1, 8'hCD); send_byte(1, 8'hEF);
        send_n(1, 1'b1, 32);
        #100;
        chk("b_fv_count", 64'(fv_b), 64'd1);
        chk("b_data", 64'(bus_b.data_out), 64'h0000_1234_56AB_CDEF);
        chk("b_busy", 64'(bus_b.busy), 64'd0);
`ifdef APA102_BRIGHT_EN
        chk("b_bright", 64'(bus_b.bright_out), 64'(10'b00001_11111));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
